// File: rtl/dma_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dma_arbiter                                                  |
// | Description : Shares the RAM port between the CPU (default owner) and two |
// |               DMA requesters. Grants are bounded bursts, and every grant  |
// |               is followed by a guaranteed CPU window. When both DMA       |
// |               requesters are waiting, they are served round-robin.        |
// |               Define DMA_ARB_STATS_EN to add per-requester grant counters |
// |               (grant_cnt0 / grant_cnt1).                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dma_arbiter #(
   parameter int unsigned BURST   = 4,   // max consecutive granted cycles (1..15)
   parameter int unsigned CPU_GAP = 1    // forced CPU cycles after each grant (0..7)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bus_arbitrate,
   output logic        bus_ack,
   input  logic        dma0_req,
   input  logic [17:0] dma0_addr,
   input  logic [15:0] dma0_data_out,
   input  logic        dma0_rd,
   input  logic        dma0_wr,
   output logic        dma0_ack,
   input  logic        dma1_req,
   input  logic [17:0] dma1_addr,
   input  logic [15:0] dma1_data_out,
   input  logic        dma1_rd,
   input  logic        dma1_wr,
   output logic        dma1_ack,
   output logic [17:0] dma_addr,
   output logic [15:0] dma_data_out,
   output logic        dma_rd,
   output logic        dma_wr,
`ifdef DMA_ARB_STATS_EN
   output logic [15:0] grant_cnt0,
   output logic [15:0] grant_cnt1,
`endif
   output logic [1:0]  owner
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   localparam logic [1:0] OWN_CPU  = 2'b00;
   localparam logic [1:0] OWN_DMA0 = 2'b01;
   localparam logic [1:0] OWN_DMA1 = 2'b10;

   localparam logic [3:0] BURST_MAX = BURST[3:0];
   localparam logic [2:0] GAP_LOAD  = CPU_GAP[2:0];

   logic [0:0] state;
   logic       rr;          // 0: dma0 preferred on a tie, 1: dma1 preferred
   logic [3:0] burst_cnt;
   logic [2:0] gap_cnt;

   logic [0:0] state_nxt;
   logic [1:0] owner_nxt;
   logic       bus_ack_nxt;
   logic       ack0_nxt;
   logic       ack1_nxt;
   logic       rr_nxt;
   logic [3:0] burst_nxt;
   logic [2:0] gap_nxt;

   // dma1 wins only if it is the sole requester or it holds the rr preference
   logic pick1;
   logic owner_req;
   assign pick1     = dma1_req && (!dma0_req || rr);
   assign owner_req = (owner == OWN_DMA1) ? dma1_req : dma0_req;

   // State register: all arbiter state, cleared synchronously by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= OWN_CPU;
         bus_ack   <= 1'b1;
         dma0_ack  <= 1'b0;
         dma1_ack  <= 1'b0;
         rr        <= 1'b0;
         burst_cnt <= 4'd0;
         gap_cnt   <= 3'd0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         bus_ack   <= bus_ack_nxt;
         dma0_ack  <= ack0_nxt;
         dma1_ack  <= ack1_nxt;
         rr        <= rr_nxt;
         burst_cnt <= burst_nxt;
         gap_cnt   <= gap_nxt;
      end
   end

   // Next-state logic: CPU window countdown, arbitration and burst termination
   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      bus_ack_nxt = bus_ack;
      ack0_nxt    = dma0_ack;
      ack1_nxt    = dma1_ack;
      rr_nxt      = rr;
      burst_nxt   = burst_cnt;
      gap_nxt     = gap_cnt;
      case (state)
         IDLE: begin
            if (gap_cnt != 3'd0) begin
               gap_nxt = gap_cnt - 3'd1;
            end else if (bus_arbitrate && (dma0_req || dma1_req)) begin
               state_nxt   = GRANT;
               bus_ack_nxt = 1'b0;
               burst_nxt   = 4'd1;
               if (pick1) begin
                  owner_nxt = OWN_DMA1;
                  ack1_nxt  = 1'b1;
               end else begin
                  owner_nxt = OWN_DMA0;
                  ack0_nxt  = 1'b1;
               end
            end
         end
         GRANT: begin
            if (!owner_req || (burst_cnt >= BURST_MAX)) begin
               state_nxt   = IDLE;
               owner_nxt   = OWN_CPU;
               bus_ack_nxt = 1'b1;
               ack0_nxt    = 1'b0;
               ack1_nxt    = 1'b0;
               gap_nxt     = GAP_LOAD;
               rr_nxt      = (owner == OWN_DMA0);
            end else begin
               burst_nxt = burst_cnt + 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output mux: only the current owner reaches the RAM port; wr beats rd
   always_comb begin
      dma_addr     = 18'd0;
      dma_data_out = 16'd0;
      dma_rd       = 1'b0;
      dma_wr       = 1'b0;
      case (owner)
         OWN_DMA0: begin
            dma_addr     = dma0_addr;
            dma_data_out = dma0_data_out;
            dma_wr       = dma0_wr;
            dma_rd       = dma0_rd && !dma0_wr;
         end
         OWN_DMA1: begin
            dma_addr     = dma1_addr;
            dma_data_out = dma1_data_out;
            dma_wr       = dma1_wr;
            dma_rd       = dma1_rd && !dma1_wr;
         end
         default: begin
            dma_addr     = 18'd0;
         end
      endcase
   end

`ifdef DMA_ARB_STATS_EN
   logic rise0;
   logic rise1;
   assign rise0 = ack0_nxt && !dma0_ack;
   assign rise1 = ack1_nxt && !dma1_ack;

   // Grant statistics: count ack rising edges, wrapping at 16 bits
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0 <= 16'd0;
         grant_cnt1 <= 16'd0;
      end else begin
         if (rise0) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (rise1) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dma_arbiter                                               |
// | Description : Self-checking bench for dma_arbiter: directed scenarios plus |
// |               randomized traffic against a behavioural grant model.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dma_arbiter;

   localparam int BURST   = 4;
   localparam int CPU_GAP = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        bus_arbitrate = 1'b0;
   logic        bus_ack;
   logic        dma0_req = 1'b0;
   logic [17:0] dma0_addr = '0;
   logic [15:0] dma0_data_out = '0;
   logic        dma0_rd = 1'b0;
   logic        dma0_wr = 1'b0;
   logic        dma0_ack;
   logic        dma1_req = 1'b0;
   logic [17:0] dma1_addr = '0;
   logic [15:0] dma1_data_out = '0;
   logic        dma1_rd = 1'b0;
   logic        dma1_wr = 1'b0;
   logic        dma1_ack;
   logic [17:0] dma_addr;
   logic [15:0] dma_data_out;
   logic        dma_rd;
   logic        dma_wr;
   logic [1:0]  owner;
`ifdef DMA_ARB_STATS_EN
   logic [15:0] grant_cnt0;
   logic [15:0] grant_cnt1;
`endif

   int checks = 0;
   int errors = 0;

   dma_arbiter #(.BURST(BURST), .CPU_GAP(CPU_GAP)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus_arbitrate (bus_arbitrate),
      .bus_ack       (bus_ack),
      .dma0_req      (dma0_req),
      .dma0_addr     (dma0_addr),
      .dma0_data_out (dma0_data_out),
      .dma0_rd       (dma0_rd),
      .dma0_wr       (dma0_wr),
      .dma0_ack      (dma0_ack),
      .dma1_req      (dma1_req),
      .dma1_addr     (dma1_addr),
      .dma1_data_out (dma1_data_out),
      .dma1_rd       (dma1_rd),
      .dma1_wr       (dma1_wr),
      .dma1_ack      (dma1_ack),
      .dma_addr      (dma_addr),
      .dma_data_out  (dma_data_out),
      .dma_rd        (dma_rd),
      .dma_wr        (dma_wr),
`ifdef DMA_ARB_STATS_EN
      .grant_cnt0    (grant_cnt0),
      .grant_cnt1    (grant_cnt1),
`endif
      .owner         (owner)
   );

   always #5 clk = ~clk;

   // Behavioural model: who holds the bus, how long it has held it, how many
   // CPU cycles have elapsed since the last grant, and who is next in line.
   int          m_owner = 0;        // 0 CPU, 1 dma0, 2 dma1
   int          m_held = 0;
   int          m_cpu_since = CPU_GAP;
   int          m_pref = 1;
   logic [15:0] m_g0 = '0;
   logic [15:0] m_g1 = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_owner = 0; m_held = 0; m_cpu_since = CPU_GAP; m_pref = 1;
         m_g0 = '0; m_g1 = '0;
      end else if (m_owner == 0) begin
         if (m_cpu_since < CPU_GAP) begin
            m_cpu_since = m_cpu_since + 1;
         end else if (bus_arbitrate && (dma0_req || dma1_req)) begin
            if (dma0_req && dma1_req) m_owner = m_pref;
            else                      m_owner = dma0_req ? 1 : 2;
            m_held = 1;
            if (m_owner == 1) m_g0 = m_g0 + 16'd1;
            else              m_g1 = m_g1 + 16'd1;
         end
      end else begin
         if (!((m_owner == 1) ? dma0_req : dma1_req) || m_held == BURST) begin
            m_pref      = (m_owner == 1) ? 2 : 1;
            m_owner     = 0;
            m_cpu_since = 0;
         end else begin
            m_held = m_held + 1;
         end
      end
   end

   task automatic clear_inputs();
      bus_arbitrate = 0;
      dma0_req = 0; dma0_addr = '0; dma0_data_out = '0; dma0_rd = 0; dma0_wr = 0;
      dma1_req = 0; dma1_addr = '0; dma1_data_out = '0; dma1_rd = 0; dma1_wr = 0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({bus_ack, dma0_ack, dma1_ack, owner} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_regs: bus_ack/ack0/ack1/owner got %b expected 10000",
                  {bus_ack, dma0_ack, dma1_ack, owner});
      end
      checks++;
      if ({dma_addr, dma_data_out, dma_rd, dma_wr} !== 36'd0) begin
         errors++;
         $display("FAIL reset_mux: got addr %0o data %0h rd %b wr %b expected all 0",
                  dma_addr, dma_data_out, dma_rd, dma_wr);
      end
   endtask

   task automatic test_arbitrate_gate();
      apply_reset();
      dma0_req = 1; dma0_addr = 18'o1000;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus_ack !== 1'b1 || dma0_ack !== 1'b0) begin
            errors++;
            $display("FAIL arb_gate cycle %0d: bus_ack %b dma0_ack %b expected 1 0",
                     i, bus_ack, dma0_ack);
         end
      end
      bus_arbitrate = 1;
      @(posedge clk); #1;
      checks++;
      if (dma0_ack !== 1'b1 || owner !== 2'b01 || bus_ack !== 1'b0) begin
         errors++;
         $display("FAIL arb_grant: dma0_ack %b owner %b bus_ack %b expected 1 01 0",
                  dma0_ack, owner, bus_ack);
      end
   endtask

   task automatic test_burst();
      logic [11:0] pat;
      pat = 12'b1111_00_1111_00;
      apply_reset();
      bus_arbitrate = 1; dma0_req = 1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         checks++;
         if (dma0_ack !== pat[11-i] || bus_ack !== !pat[11-i]) begin
            errors++;
            $display("FAIL burst cycle %0d: dma0_ack %b bus_ack %b expected %b %b",
                     i, dma0_ack, bus_ack, pat[11-i], !pat[11-i]);
         end
      end
   endtask

   task automatic test_round_robin();
      int seq[3];
      int n = 0;
      logic p0 = 0;
      logic p1 = 0;
      apply_reset();
      bus_arbitrate = 1; dma0_req = 1; dma1_req = 1;
      dma0_addr = 18'o1000; dma1_addr = 18'o2000;
      for (int c = 0; c < 40 && n < 3; c++) begin
         @(posedge clk); #1;
         if (dma0_ack && !p0) begin seq[n] = 1; n++; end
         if (dma1_ack && !p1) begin seq[n] = 2; n++; end
         if (dma0_ack || dma1_ack) begin
            checks++;
            if (dma_addr !== (dma0_ack ? 18'o1000 : 18'o2000)) begin
               errors++;
               $display("FAIL rr_addr: dma_addr %0o expected %0o",
                        dma_addr, dma0_ack ? 18'o1000 : 18'o2000);
            end
         end
         p0 = dma0_ack; p1 = dma1_ack;
      end
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL rr_timeout: grants seen %0d expected 3", n);
      end else if (seq[0] != 1 || seq[1] != 2 || seq[2] != 1) begin
         errors++;
         $display("FAIL rr_order: got %0d %0d %0d expected 1 2 1", seq[0], seq[1], seq[2]);
      end
   endtask

   task automatic test_mux();
      apply_reset();
      bus_arbitrate = 1; dma0_req = 1;
      @(posedge clk); #1;
      dma0_rd = 1; dma0_wr = 1; dma0_data_out = 16'hA5A5; dma0_addr = 18'o1234;
      dma1_rd = 1; dma1_wr = 1; dma1_data_out = 16'h5A5A; dma1_addr = 18'o7777;
      #1;
      checks++;
      if (dma_wr !== 1'b1 || dma_rd !== 1'b0 || dma_data_out !== 16'hA5A5 || dma_addr !== 18'o1234) begin
         errors++;
         $display("FAIL mux_rdwr: wr %b rd %b data %0h addr %0o expected 1 0 a5a5 1234",
                  dma_wr, dma_rd, dma_data_out, dma_addr);
      end
      dma0_rd = 0; dma0_wr = 0;
      #1;
      checks++;
      if (dma_wr !== 1'b0 || dma_rd !== 1'b0) begin
         errors++;
         $display("FAIL mux_nonowner: wr %b rd %b expected 0 0", dma_wr, dma_rd);
      end
      dma0_rd = 1;
      #1;
      checks++;
      if (dma_rd !== 1'b1 || dma_wr !== 1'b0) begin
         errors++;
         $display("FAIL mux_rd: rd %b wr %b expected 1 0", dma_rd, dma_wr);
      end
   endtask

   task automatic test_reset_mid_grant();
      apply_reset();
      bus_arbitrate = 1; dma0_req = 1; dma0_wr = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      checks++;
      if ({bus_ack, dma0_ack, dma1_ack, owner, dma_wr} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_mid_grant: bus_ack/ack0/ack1/owner/dma_wr got %b expected 100000",
                  {bus_ack, dma0_ack, dma1_ack, owner, dma_wr});
      end
      reset = 0;
      clear_inputs();
   endtask

   task automatic test_random();
      logic [1:0]  e_owner;
      logic [17:0] e_addr;
      logic [15:0] e_data;
      logic        e_rd, e_wr;
      int          bad_reg = 0;
      int          bad_mux = 0;
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         reset         = ($urandom_range(0, 299) == 0);
         bus_arbitrate = ($urandom_range(0, 9) < 7);
         dma0_req      = ($urandom_range(0, 9) < 7);
         dma1_req      = ($urandom_range(0, 9) < 6);
         @(posedge clk); #1;
         e_owner = m_owner[1:0];
         checks++;
         if (bus_ack !== (m_owner == 0) || dma0_ack !== (m_owner == 1) ||
             dma1_ack !== (m_owner == 2) || owner !== e_owner) begin
            errors++;
            if (bad_reg < 5)
               $display("FAIL rand_regs cycle %0d: bus_ack %b ack0 %b ack1 %b owner %b expected owner %b",
                        c, bus_ack, dma0_ack, dma1_ack, owner, e_owner);
            bad_reg++;
         end
`ifdef DMA_ARB_STATS_EN
         checks++;
         if (grant_cnt0 !== m_g0 || grant_cnt1 !== m_g1) begin
            errors++;
            $display("FAIL rand_stats cycle %0d: cnt0 %0d cnt1 %0d expected %0d %0d",
                     c, grant_cnt0, grant_cnt1, m_g0, m_g1);
         end
`endif
         dma0_addr = 18'($urandom); dma0_data_out = 16'($urandom);
         dma0_rd = 1'($urandom); dma0_wr = 1'($urandom);
         dma1_addr = 18'($urandom); dma1_data_out = 16'($urandom);
         dma1_rd = 1'($urandom); dma1_wr = 1'($urandom);
         #1;
         e_addr = 0; e_data = 0; e_rd = 0; e_wr = 0;
         if (m_owner == 1) begin
            e_addr = dma0_addr; e_data = dma0_data_out; e_wr = dma0_wr; e_rd = dma0_rd & ~dma0_wr;
         end else if (m_owner == 2) begin
            e_addr = dma1_addr; e_data = dma1_data_out; e_wr = dma1_wr; e_rd = dma1_rd & ~dma1_wr;
         end
         checks++;
         if (dma_addr !== e_addr || dma_data_out !== e_data || dma_rd !== e_rd || dma_wr !== e_wr) begin
            errors++;
            if (bad_mux < 5)
               $display("FAIL rand_mux cycle %0d: addr %0o data %0h rd %b wr %b expected %0o %0h %b %b",
                        c, dma_addr, dma_data_out, dma_rd, dma_wr, e_addr, e_data, e_rd, e_wr);
            bad_mux++;
         end
      end
      reset = 0;
      clear_inputs();
   endtask

`ifdef DMA_ARB_STATS_EN
   task automatic test_stats();
      int   n = 0;
      logic p1 = 0;
      apply_reset();
      bus_arbitrate = 1; dma1_req = 1;
      for (int c = 0; c < 60 && n < 3; c++) begin
         @(posedge clk); #1;
         if (dma1_ack && !p1) n++;
         p1 = dma1_ack;
      end
      checks++;
      if (n != 3 || grant_cnt1 !== 16'd3 || grant_cnt0 !== 16'd0) begin
         errors++;
         $display("FAIL stats_count: grants %0d cnt1 %0d cnt0 %0d expected 3 3 0",
                  n, grant_cnt1, grant_cnt0);
      end
      clear_inputs();
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_arbitrate_gate();
      test_burst();
      test_round_robin();
      test_mux();
      test_reset_mid_grant();
      test_random();
`ifdef DMA_ARB_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
